// File: rtl/router_xbar_rr.sv
// router_xbar_rr: N-port packet crossbar with per-output round-robin arbitration.
//
// Each input presents a head packet; its destination field indexes ROUTE_TABLE
// to pick an output port. Packets whose table entry is >= NUM_PORTS are dropped
// (popped and counted). Each output owns a registered slot that holds its packet
// until the downstream receiver signals ready; a slot may drain and refill in the
// same cycle, giving one packet per cycle per output under continuous ready.
//
// Ports:
//   clock          in   clock, all state updates on the rising edge
//   reset          in   synchronous active-high reset
//   pkt_in         in   head packet per input, input i at [i*PKT_W +: PKT_W]
//   pkt_in_avail   in   input i has a valid head packet
//   read_from_ib   out  combinational pop strobe (granted or dropped this cycle)
//   pkt_out        out  registered packet per output slot
//   pkt_out_avail  out  registered valid per output slot
//   ready_to_recv  in   downstream of output o accepts pkt_out[o] this cycle
//   drop_count     out  saturating count of dropped packets
module router_xbar_rr #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned PKT_W     = 32,
  parameter int unsigned DEST_LSB  = 0,
  parameter int unsigned DEST_W    = 4,
  parameter logic [(2**DEST_W)*8-1:0] ROUTE_TABLE = 128'h01010101_01010101_01010101_01030200,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_PORTS*PKT_W-1:0] pkt_in,
  input  logic [NUM_PORTS-1:0]       pkt_in_avail,
  output logic [NUM_PORTS-1:0]       read_from_ib,
  output logic [NUM_PORTS*PKT_W-1:0] pkt_out,
  output logic [NUM_PORTS-1:0]       pkt_out_avail,
  input  logic [NUM_PORTS-1:0]       ready_to_recv,
  output logic [CNT_W-1:0]           drop_count
);

  localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Registered state
  logic [PKT_W-1:0] slot_q [NUM_PORTS];
  logic [PKT_W-1:0] slot_d [NUM_PORTS];
  logic [NUM_PORTS-1:0] avail_q, avail_d;
  logic [PTR_W-1:0] rr_q [NUM_PORTS];
  logic [PTR_W-1:0] rr_d [NUM_PORTS];
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Per-input lookup results
  logic [PKT_W-1:0]     pkt_arr [NUM_PORTS];
  logic [7:0]           tgt     [NUM_PORTS];
  logic [NUM_PORTS-1:0] drop;
  logic [NUM_PORTS-1:0] routable;

  // Per-output arbitration results
  logic [NUM_PORTS-1:0] gnt_vld;
  logic [PTR_W-1:0]     gnt_idx [NUM_PORTS];
  logic [NUM_PORTS-1:0] in_gnt;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_io
    assign pkt_arr[g] = pkt_in[g*PKT_W +: PKT_W];
    assign pkt_out[g*PKT_W +: PKT_W] = slot_q[g];
  end

  always_comb begin : lookup
    logic [DEST_W-1:0] dest;
    dest     = '0;
    drop     = '0;
    routable = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      dest        = pkt_in[i*PKT_W + DEST_LSB +: DEST_W];
      tgt[i]      = ROUTE_TABLE[{dest, 3'b000} +: 8];
      drop[i]     = pkt_in_avail[i] && (tgt[i] >= 8'(NUM_PORTS));
      routable[i] = pkt_in_avail[i] && (tgt[i] <  8'(NUM_PORTS));
    end
  end

  // Search starts at rr_q[o] and wraps; first matching requester wins.
  // A slot is only offered when it is empty or being drained this cycle.
  always_comb begin : arbitrate
    int unsigned       idx;
    logic [PTR_W-1:0]  idx_p;
    idx     = 0;
    idx_p   = '0;
    gnt_vld = '0;
    in_gnt  = '0;
    for (int unsigned o = 0; o < NUM_PORTS; o++) begin
      gnt_idx[o] = '0;
      if (!avail_q[o] || ready_to_recv[o]) begin
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
          idx = 32'(rr_q[o]) + k;
          if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
          idx_p = PTR_W'(idx);
          if (!gnt_vld[o] && routable[idx_p] && (tgt[idx_p] == 8'(o))) begin
            gnt_vld[o] = 1'b1;
            gnt_idx[o] = idx_p;
          end
        end
      end
      if (gnt_vld[o]) in_gnt[gnt_idx[o]] = 1'b1;
    end
  end

  always_comb begin : next_state
    int unsigned nxt;
    nxt     = 0;
    avail_d = avail_q;
    for (int unsigned o = 0; o < NUM_PORTS; o++) begin
      slot_d[o] = slot_q[o];
      rr_d[o]   = rr_q[o];
      if (gnt_vld[o]) begin
        slot_d[o]  = pkt_arr[gnt_idx[o]];
        avail_d[o] = 1'b1;
        nxt = 32'(gnt_idx[o]) + 1;
        if (nxt >= NUM_PORTS) nxt = 0;
        rr_d[o] = PTR_W'(nxt);
      end else if (ready_to_recv[o]) begin
        avail_d[o] = 1'b0;
      end
    end
    // Increment once per dropping input, stopping at all-ones.
    cnt_d = cnt_q;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (drop[i] && (cnt_d != '1)) cnt_d = cnt_d + CNT_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      avail_q <= '0;
      cnt_q   <= '0;
      for (int unsigned o = 0; o < NUM_PORTS; o++) begin
        slot_q[o] <= '0;
        rr_q[o]   <= '0;
      end
    end else begin
      avail_q <= avail_d;
      cnt_q   <= cnt_d;
      for (int unsigned o = 0; o < NUM_PORTS; o++) begin
        slot_q[o] <= slot_d[o];
        rr_q[o]   <= rr_d[o];
      end
    end
  end

  assign read_from_ib  = reset ? '0 : (drop | in_gnt);
  assign pkt_out_avail = avail_q;
  assign drop_count    = cnt_q;

endmodule

// File: tb/tb_router_xbar_rr.sv
// Directed bench for router_xbar_rr: reset, routing latency, round-robin order,
// output hold under backpressure, drop counting with saturation, independent
// per-output ready, and reset mid-stream.
module tb_router_xbar_rr;

  localparam int unsigned N = 4;
  localparam int unsigned W = 32;
  // Entry 0->0, 1->2, 2->3, 3->1, 7->drop, rest->1
  localparam logic [127:0] TBL = 128'h01010101_01010101_FF010101_01030200;

  logic           clock = 1'b0;
  logic           reset;
  logic [W-1:0]   pin [N];
  logic [N*W-1:0] pkt_in;
  logic [N-1:0]   avail, ready;
  logic [N-1:0]   rd, out_avail, rd2, out_avail2;
  logic [N*W-1:0] pkt_out, pkt_out2;
  logic [15:0]    dc;
  logic [1:0]     dc2;

  int checks = 0;
  int errors = 0;

  assign pkt_in = {pin[3], pin[2], pin[1], pin[0]};

  always #5 clock = ~clock;

  router_xbar_rr #(.NUM_PORTS(N), .PKT_W(W), .DEST_LSB(0), .DEST_W(4),
                   .ROUTE_TABLE(TBL), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .pkt_in(pkt_in), .pkt_in_avail(avail),
    .read_from_ib(rd), .pkt_out(pkt_out), .pkt_out_avail(out_avail),
    .ready_to_recv(ready), .drop_count(dc));

  // Narrow counter copy sharing the same stimulus, for saturation.
  router_xbar_rr #(.NUM_PORTS(N), .PKT_W(W), .DEST_LSB(0), .DEST_W(4),
                   .ROUTE_TABLE(TBL), .CNT_W(2)) dut_sat (
    .clock(clock), .reset(reset), .pkt_in(pkt_in), .pkt_in_avail(avail),
    .read_from_ib(rd2), .pkt_out(pkt_out2), .pkt_out_avail(out_avail2),
    .ready_to_recv(ready), .drop_count(dc2));

  function automatic logic [W-1:0] mk(input logic [7:0] id, input logic [3:0] dest);
    return {16'hA500, id, 4'h0, dest};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    avail = '0;
    ready = 4'hF;
    for (int i = 0; i < 4; i++) pin[i] = '0;
    step();
    step();

    // Reset state; pops suppressed while reset is high
    avail = 4'hF;
    for (int i = 0; i < 4; i++) pin[i] = mk(8'(i), 4'd0);
    #1;
    chk("rst_read", 32'(rd), 32'h0);
    chk("rst_avail", 32'(out_avail), 32'h0);
    chk("rst_slot0", pkt_out[31:0], 32'h0);
    chk("rst_dc", 32'(dc), 32'h0);
    chk("rst_dc_sat", 32'(dc2), 32'h0);

    // Single packet, dest 1 -> output 2, one-cycle latency
    reset = 1'b0;
    avail = 4'b0001;
    pin[0] = mk(8'h10, 4'd1);
    #1 chk("t1_read", 32'(rd), 32'h1);
    step();
    chk("t1_avail", 32'(out_avail), 32'h4);
    chk("t1_slot2", pkt_out[95:64], mk(8'h10, 4'd1));
    avail = '0;
    #1 chk("t1_read_idle", 32'(rd), 32'h0);
    step();
    chk("t1_drain", 32'(out_avail), 32'h0);

    // Round robin on output 0 with wrap-around
    for (int i = 0; i < 4; i++) pin[i] = mk(8'(8'h20 + i), 4'd0);
    avail = 4'hF;
    for (int c = 0; c < 5; c++) begin
      logic [3:0] e;
      e = 4'b0001 << (c % 4);
      #1 chk("t2_read", 32'(rd), 32'(e));
      step();
      chk("t2_slot0", pkt_out[31:0], mk(8'(8'h20 + (c % 4)), 4'd0));
      chk("t2_avail0", 32'(out_avail[0]), 32'h1);
    end
    avail = '0;
    step();
    chk("t2_drain", 32'(out_avail), 32'h0);

    // Hold on output 3 under backpressure
    ready = 4'b0111;
    avail = 4'b0001;
    pin[0] = mk(8'h30, 4'd2);
    #1 chk("t3_load_read", 32'(rd), 32'h1);
    step();
    chk("t3_load_avail", 32'(out_avail), 32'h8);
    chk("t3_load_slot3", pkt_out[127:96], mk(8'h30, 4'd2));
    avail = 4'b0010;
    pin[1] = mk(8'h31, 4'd2);
    for (int c = 0; c < 5; c++) begin
      #1 chk("t3_hold_read", 32'(rd), 32'h0);
      step();
      chk("t3_hold_slot3", pkt_out[127:96], mk(8'h30, 4'd2));
      chk("t3_hold_avail", 32'(out_avail), 32'h8);
    end
    ready = 4'hF;
    #1 chk("t3_rel_read", 32'(rd), 32'h2);
    step();
    chk("t3_rel_slot3", pkt_out[127:96], mk(8'h31, 4'd2));
    chk("t3_rel_avail", 32'(out_avail), 32'h8);
    avail = '0;
    step();
    chk("t3_drain", 32'(out_avail), 32'h0);

    // Drops: inputs 0 and 2 to dest 7
    pin[0] = mk(8'h40, 4'd7);
    pin[2] = mk(8'h42, 4'd7);
    avail = 4'b0101;
    #1 chk("t4_read", 32'(rd), 32'h5);
    step();
    chk("t4_avail", 32'(out_avail), 32'h0);
    chk("t4_dc", 32'(dc), 32'd2);
    chk("t4_dc_sat", 32'(dc2), 32'd2);
    chk("t4_read2", 32'(rd), 32'h5);
    step();
    chk("t4_dc_b", 32'(dc), 32'd4);
    chk("t4_dc_sat_b", 32'(dc2), 32'd3);
    avail = 4'b0001;
    step();
    chk("t4_dc_c", 32'(dc), 32'd5);
    chk("t4_dc_sat_c", 32'(dc2), 32'd3);
    avail = '0;

    // Independent per-output ready
    ready = 4'b0000;
    pin[0] = mk(8'h50, 4'd0);
    pin[1] = mk(8'h51, 4'd3);
    avail = 4'b0011;
    #1 chk("t5_fill_read", 32'(rd), 32'h3);
    step();
    chk("t5_fill_avail", 32'(out_avail), 32'h3);
    chk("t5_fill_slot0", pkt_out[31:0], mk(8'h50, 4'd0));
    chk("t5_fill_slot1", pkt_out[63:32], mk(8'h51, 4'd3));
    pin[2] = mk(8'h52, 4'd0);
    pin[3] = mk(8'h53, 4'd3);
    avail = 4'b1100;
    ready = 4'b0001;
    #1 chk("t5_read", 32'(rd), 32'h4);
    step();
    chk("t5_slot0", pkt_out[31:0], mk(8'h52, 4'd0));
    chk("t5_slot1", pkt_out[63:32], mk(8'h51, 4'd3));
    chk("t5_avail", 32'(out_avail), 32'h3);

    // Fill all outputs, then reset mid-stream
    ready = 4'b0000;
    pin[0] = mk(8'h60, 4'd1);
    pin[1] = mk(8'h61, 4'd2);
    avail = 4'b0011;
    #1 chk("t6_fill_read", 32'(rd), 32'h3);
    step();
    chk("t6_fill_avail", 32'(out_avail), 32'hF);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) pin[i] = mk(8'(8'h70 + i), 4'd0);
    avail = 4'hF;
    #1 chk("t6_rst_read", 32'(rd), 32'h0);
    step();
    chk("t6_rst_avail", 32'(out_avail), 32'h0);
    chk("t6_rst_dc", 32'(dc), 32'h0);
    chk("t6_rst_dc_sat", 32'(dc2), 32'h0);
    reset = 1'b0;
    ready = 4'hF;
    #1 chk("t6_restart_read", 32'(rd), 32'h1);
    step();
    chk("t6_restart_slot0", pkt_out[31:0], mk(8'h70, 4'd0));
    chk("t6_restart_avail", 32'(out_avail), 32'h1);
    chk("t6_next_read", 32'(rd), 32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
